mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 126 ++++++++++++
 tb/tb_mem_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Byte-stream memory loader: length-prefixed word stream with mod-256 checksum,
// writing words to an instruction/data memory while holding the CPU in reset.
module mem_loader #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] HLT_WORD = 32'hFC000000
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic              hlt_seen
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_HI = 3'd1;
    localparam logic [2:0] LEN_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] CSUM   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    // Largest legal word count; one bit wider than the length field so 2**16 fits.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    logic [2:0]      state;
    logic [7:0]      len_hi;
    logic [15:0]     n_words;
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_cnt;
    logic [23:0]     partial;
    logic [7:0]      sum;

    logic        take;
    logic [15:0] len_full;
    logic        last_word;

    assign take      = rx_valid && rx_ready;
    assign len_full  = {len_hi, rx_data};
    assign last_word = (17'(word_idx) + 17'd1) == {1'b0, n_words};

    // Status outputs are pure decodes of the state register, so reset clears them for free.
    assign rx_ready  = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CSUM);
    assign mem_we    = (state == WRITE);
    assign cpu_hold  = (state != DONE);
    assign load_done = (state == DONE);
    assign load_err  = (state == ERR);

    always_ff @(posedge clk1) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            state     <= IDLE;
            len_hi    <= '0;
            n_words   <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            partial   <= '0;
            sum       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            hlt_seen  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN_HI;
                        hlt_seen <= 1'b0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        sum      <= '0;
                    end
                end
                LEN_HI: begin
                    if (take) begin
                        len_hi <= rx_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        n_words <= len_full;
                        if (len_full == 16'd0)
                            state <= CSUM;
                        else if ({1'b0, len_full} > MAX_WORDS)
                            state <= ERR;
                        else
                            state <= DATA;
                    end
                end
                DATA: begin
                    if (take) begin
                        sum      <= sum + rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        partial  <= {partial[15:0], rx_data};
                        if (byte_cnt == 2'd3) begin
                            // Write port registers only move here, so they hold between strobes.
                            mem_wdata <= {partial, rx_data};
                            mem_addr  <= word_idx[ADDR_W-1:0];
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_wdata == HLT_WORD)
                        hlt_seen <= 1'b1;
                    word_idx <= word_idx + (ADDR_W+1)'(1);
                    state    <= last_word ? CSUM : DATA;
                end
                CSUM: begin
                    if (take)
                        state <= (rx_data == 8'(~sum + 8'd1)) ? DONE : ERR;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: scoreboard of expected memory writes plus
// per-scenario status checks.
module tb_mem_loader;

    localparam int AW = 4;

    logic          clk1 = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic          hlt_seen;

    mem_loader #(.ADDR_W(AW)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .hlt_seen  (hlt_seen)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] words[$];
    logic [31:0] cap [16];
    logic [31:0] ref_cap [16];
    int          tests_run = 0;
    int          failed = 0;
    int          we_count = 0;
    int          duty = 100;

    // Scoreboard: every write strobe must match the next expected (addr, data).
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            we_count++;
            tests_run++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    failed++;
                    $display("FAIL write addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end
            end
            cap[mem_addr] = mem_wdata;
        end
        if (mem_we === 1'b1 && rx_ready === 1'b1) begin
            failed++;
            $display("FAIL we_with_ready mem_we=1 rx_ready=1 expected never both");
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  budget;
        bit  done;
        budget = 0;
        done   = 1'b0;
        while (!done) begin
            rx_data  = b;
            rx_valid = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            done     = rx_valid && rx_ready;
            tick();
            budget++;
            if (!done && budget > 2000) begin
                tests_run++;
                failed++;
                $display("FAIL byte_timeout byte=%h rx_ready=%b expected accepted", b, rx_ready);
                done = 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    // Drives a full stream for the first n entries of words[]; bad corrupts the checksum.
    task automatic run_load(input logic [15:0] n, input bit bad);
        logic [7:0]  s;
        logic [7:0]  c;
        logic [31:0] w;
        s = 8'h00;
        pulse_start();
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            sb.push_back('{addr: AW'(i), data: w});
            for (int b = 3; b >= 0; b--) begin
                send_byte(w[b*8 +: 8]);
                s = s + w[b*8 +: 8];
            end
        end
        c = ~s + 8'd1;
        if (bad) c = c + 8'd1;
        send_byte(c);
    endtask

    task automatic check_status(input string name, input int exp_we,
                                input logic exp_done, input logic exp_err);
        tests_run++;
        if (we_count !== exp_we || load_done !== exp_done || load_err !== exp_err ||
            cpu_hold !== !exp_done || sb.size() != 0) begin
            failed++;
            $display("FAIL %s writes=%0d done=%b err=%b hold=%b pending=%0d expected writes=%0d done=%b err=%b hold=%b pending=0",
                     name, we_count, load_done, load_err, cpu_hold, sb.size(),
                     exp_we, exp_done, exp_err, !exp_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
        repeat (3) tick();
        tests_run++;
        if ({rx_ready, mem_we, load_done, load_err, hlt_seen, cpu_hold} !== 6'b000001) begin
            failed++;
            $display("FAIL reset_flags got=%b expected=000001",
                     {rx_ready, mem_we, load_done, load_err, hlt_seen, cpu_hold});
        end
        tests_run++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0) begin
            failed++;
            $display("FAIL reset_mem addr=%0d data=%h expected 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
        tick();
        tests_run++;
        if (rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            failed++;
            $display("FAIL reset_idle rx_ready=%b cpu_hold=%b expected 0/1", rx_ready, cpu_hold);
        end
    endtask

    task automatic test_good_load();
        words = '{32'h28010009, 32'hFC000000};
        we_count = 0;
        run_load(16'd2, 1'b0);
        check_status("good_load", 2, 1'b1, 1'b0);
        tests_run++;
        if (hlt_seen !== 1'b1 || mem_addr !== AW'(1) || mem_wdata !== 32'hFC000000) begin
            failed++;
            $display("FAIL good_hold hlt=%b addr=%0d data=%h expected 1/1/fc000000",
                     hlt_seen, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_bad_checksum();
        words = '{32'h28010009, 32'hFC000000};
        we_count = 0;
        run_load(16'd2, 1'b1);
        check_status("bad_checksum", 2, 1'b0, 1'b1);
    endtask

    task automatic test_zero_length();
        we_count = 0;
        pulse_start();
        tests_run++;
        if (load_err !== 1'b0 || hlt_seen !== 1'b0 || rx_ready !== 1'b1) begin
            failed++;
            $display("FAIL start_clears err=%b hlt=%b rx_ready=%b expected 0/0/1",
                     load_err, hlt_seen, rx_ready);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check_status("zero_length", 0, 1'b1, 1'b0);
    endtask

    task automatic test_too_long();
        we_count = 0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h11);
        check_status("too_long", 0, 1'b0, 1'b1);
        tests_run++;
        if (rx_ready !== 1'b0) begin
            failed++;
            $display("FAIL too_long_ready rx_ready=%b expected 0", rx_ready);
        end
    endtask

    task automatic test_full_depth();
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back($urandom());
        we_count = 0;
        run_load(16'd16, 1'b0);
        check_status("full_depth", 16, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back($urandom());
        for (int i = 0; i < 16; i++) cap[i] = 32'h0;
        we_count = 0;
        run_load(16'd5, 1'b0);
        check_status("nostall_ref", 5, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            ref_cap[i] = cap[i];
            cap[i] = 32'h0;
        end
        duty = 30;
        we_count = 0;
        run_load(16'd5, 1'b0);
        duty = 100;
        check_status("stall_load", 5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (cap[i] !== ref_cap[i]) begin
                failed++;
                $display("FAIL stall_mem[%0d] got=%h expected=%h", i, cap[i], ref_cap[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] w;
        logic [7:0]  s;
        w = 32'h12345678;
        s = 8'h12 + 8'h34 + 8'h56 + 8'h78;
        we_count = 0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        sb.push_back('{addr: AW'(0), data: w});
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        pulse_start();
        send_byte(w[15:8]);
        send_byte(w[7:0]);
        send_byte(~s + 8'd1);
        check_status("start_ignored", 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        words = '{32'hA1B2C3D4, 32'h01020304};
        we_count = 0;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        sb.push_back('{addr: AW'(0), data: words[0]});
        for (int b = 3; b >= 0; b--) send_byte(words[0][b*8 +: 8]);
        send_byte(words[1][31:24]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check_status("mid_reset_abort", 1, 1'b0, 1'b0);
        words = '{32'h5EEDF00D, 32'h0BADCAFE};
        we_count = 0;
        run_load(16'd2, 1'b0);
        check_status("reload", 2, 1'b1, 1'b0);
        tests_run++;
        if (cap[0] !== 32'h5EEDF00D) begin
            failed++;
            $display("FAIL reload_addr0 got=%h expected=5eedf00d", cap[0]);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_zero_length();
        test_too_long();
        test_full_depth();
        test_stall();
        test_start_ignored();
        test_reset_mid_load();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
